fx_overdrive: RTL and testbench
===============================

// Module: fx_overdrive
// PURPOSE
//  Multi-channel distortion FX: drive gain, selectable clipper, one-pole tone LPF and dry/wet mix.
//  Successor to the stereo distortion slot (FX 4). It generalises to N_CH channels and adds
//  clip modes, tone filtering and real mixing.
//  Channels are time-multiplexed through one shared datapath once per sample_en.
//  Sits in the FX chain between the preceding FX slot and the output mixer.
// PARAMETERS
//  DATA_W   16  signed audio sample width (two's complement)
//  PARAM_W  8   unsigned width of fx_drive / fx_tone / fx_mix
//  N_CH     2   channel count, >=1
// PORTS
//  clk        in   1              system clock, single clock domain
//  reset_n    in   1              asynchronous, active-low reset
//  sample_en  in   1              one-cycle strobe: new frame present on audio_in
//  audio_in   in   N_CH*DATA_W    packed [N_CH-1:0][DATA_W-1:0] input frame
//  fx_drive   in   PARAM_W        drive amount
//  fx_tone    in   PARAM_W        LPF coefficient (255 = no filtering)
//  fx_mix     in   PARAM_W        0 = all dry, 255 = all wet
//  fx_mode    in   2              0 bypass-clip, 1 hard clip, 2 soft clip, 3 = hard clip
//  audio_out  out  N_CH*DATA_W    processed frame, held between updates
//  out_valid  out  1              one-cycle pulse when audio_out updates
//  busy       out  1              high while a frame is being processed
//  overrun    out  1              sticky; set on sample_en while busy, cleared only by reset
// BEHAVIOUR
//  Reset (async, any time): audio_out, out_valid, busy, overrun, LPF state[all ch], channel counter -> 0.
//  FSM is IDLE -> GAIN -> CLIP -> TONE -> MIX; MIX returns to GAIN for each channel, then DONE -> IDLE.
//  - IDLE: on sample_en, latch audio_in, fx_drive, fx_tone, fx_mix and fx_mode into a frame register.
//    Set ch=0, busy=1.
//  - Frame-register parameters are used for the whole frame; port changes mid-frame have no effect.
//  - GAIN: p = x*(16+drive) >>> 4, full width DATA_W+PARAM_W+2 signed (gain 1.0 to 16.94).
//  - CLIP: T = 2^(DATA_W-2).
//    - mode 0: w = sat(p).
//    - mode 1/3: w = sat(p).
//    - mode 2: if |p|<=T then w=p, else w = sign(p)*(T + ((|p|-T)>>>2)), then sat().
//    - sat() clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//    - mode 0 is the gain-only path; the LPF and mix stages still apply.
//  - TONE: y = s[ch] + (((w - s[ch]) * (tone+1)) >>> PARAM_W). Write s[ch] = y.
//    - tone=255 gives y=w exactly.
//    - Difference is computed at DATA_W+1 bits; no overflow is possible.
//  - MIX: if mix==255 then o=y, else o = x + (((y - x)*mix) >>> PARAM_W), where x is the dry input.
//    - Result is a convex blend, so no saturation is needed. Store o into out_buf[ch].
//  - After MIX: if ch==N_CH-1 go to DONE, else ch++ and return to GAIN.
//  - DONE: audio_out <= out_buf (all channels at once), out_valid=1 for exactly this cycle. busy=0 next cycle.
//  - Latency: out_valid asserts 4*N_CH+1 cycles after the sample_en cycle (9 for N_CH=2).
//    A new frame can be accepted in the cycle after out_valid.
//  - sample_en while busy (including in the DONE cycle): ignored, overrun<=1, current frame unaffected.
//  - All shifts are arithmetic (floor rounding); no dither.
//  - Min sample period: 4*N_CH+2 clk cycles; the integrator guarantees this.
// STRUCTURE
//  Shared package fx_pkg:
//  - fx_mode_e (FX_BYPASS, FX_HARD, FX_SOFT, FX_RSVD)
//  - fsm state typedef
//  - function sat_w(): generic saturate-to-DATA_W
//  Sub-module fx_clip_unit: combinational gain+clip (x, drive, mode -> w). Reused by later FX slots.
//  Top level holds the FSM, frame register, LPF state array, out_buf and the one shared multiplier.
// TESTING  (DATA_W=16, PARAM_W=8, N_CH=2)
//  1. Async reset mid-frame (assert at cycle 3 after sample_en).
//     -> all outputs 0 immediately, no out_valid, next frame processes normally.
//  2. mode0, drive=0, tone=255, mix=255, in={0x1234,0xEDCC}.
//     -> out={0x1234,0xEDCC}, out_valid exactly 9 cycles after sample_en.
//  3. mode1, drive=255, tone=255, mix=255, in={0x1000,0xF000} -> out={0x7FFF,0x8000}.
//  4. mode2, drive=16 (gain 2.0), tone=255, mix=255, in=0x3000 -> p=0x6000, out=0x4800.
//  5. Tone step: mode0, drive=0, tone=127, mix=255, in=0x4000 for 3 frames.
//     -> out 0x2000, 0x3000, 0x3800; ch1 held at 0 stays 0 (independent state).
//  6. mix=0 with mode1 drive=255 -> out equals dry input.
//     Pulse sample_en at cycle 4 of busy -> overrun=1 and stays 1; frame result unchanged.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared types and helpers for the FX slot family: clip modes, FSM states and a
// generic saturate-to-width function.
package fx_pkg;

  typedef enum logic [1:0] {
    FX_BYPASS = 2'd0,
    FX_HARD   = 2'd1,
    FX_SOFT   = 2'd2,
    FX_RSVD   = 2'd3
  } fx_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAIN,
    ST_CLIP,
    ST_TONE,
    ST_MIX,
    ST_DONE
  } fx_state_e;

  // Clamp a wide signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fx_overdrive_if.sv
// Frame/parameter handshake between the previous FX slot, the overdrive slot
// and the output mixer.
interface fx_overdrive_if #(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 8,
  parameter int N_CH    = 2
);
  logic                         sample_en;
  logic [N_CH-1:0][DATA_W-1:0]  audio_in;
  logic [PARAM_W-1:0]           fx_drive;
  logic [PARAM_W-1:0]           fx_tone;
  logic [PARAM_W-1:0]           fx_mix;
  logic [1:0]                   fx_mode;
  logic [N_CH-1:0][DATA_W-1:0]  audio_out;
  logic                         out_valid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output sample_en, audio_in, fx_drive, fx_tone, fx_mix, fx_mode,
    input  audio_out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_en, audio_in, fx_drive, fx_tone, fx_mix, fx_mode,
    output audio_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/fx_clip_unit.sv
// Combinational drive gain followed by the selectable clipper (hard or soft knee),
// saturated back to the sample width.
module fx_clip_unit
  import fx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 8
) (
  input  logic signed [DATA_W-1:0]  x,
  input  logic        [PARAM_W-1:0] drive,
  input  fx_mode_e                  mode,
  output logic signed [DATA_W-1:0]  w
);
  localparam int P_W = DATA_W + PARAM_W + 2;
  localparam logic signed [P_W-1:0] KNEE = P_W'(1) <<< (DATA_W - 2);

  logic signed [PARAM_W+1:0] gain;
  logic signed [P_W-1:0]     p, mag, sp;

  always_comb begin
    gain = $signed({2'b00, drive}) + (PARAM_W+2)'(16);
    p    = (P_W'(x) * P_W'(gain)) >>> 4;
    mag  = (p < 0) ? -p : p;
    sp   = p;
    // Above the knee the soft mode compresses the excess by 4:1, symmetric in sign.
    if (mode == FX_SOFT && mag > KNEE) begin
      sp = KNEE + ((mag - KNEE) >>> 2);
      if (p < 0) sp = -sp;
    end
    w = DATA_W'(sat_w(64'(sp), DATA_W));
  end

endmodule

// File: rtl/fx_overdrive.sv
// Multi-channel overdrive: channels run one after another through gain/clip,
// a one-pole tone LPF and a dry/wet mix, sharing one multiplier for tone and mix.
module fx_overdrive
  import fx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 8,
  parameter int N_CH    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  fx_overdrive_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int M_W  = DATA_W + PARAM_W + 3;

  fx_state_e                   state;
  logic [CH_W-1:0]             ch;
  logic [N_CH-1:0][DATA_W-1:0] fr_x, lpf, out_buf, out_nxt;
  logic [PARAM_W-1:0]          fr_drive, fr_tone, fr_mix;
  fx_mode_e                    fr_mode;
  logic signed [DATA_W-1:0]    x_cur, s_cur, w_cu, w_r, y_r, y_nxt, o_nxt;
  logic signed [DATA_W:0]      mul_a;
  logic signed [PARAM_W+1:0]   mul_b;
  logic signed [M_W-1:0]       prod, acc;

  assign x_cur = fr_x[ch];
  assign s_cur = lpf[ch];

  fx_clip_unit #(.DATA_W(DATA_W), .PARAM_W(PARAM_W)) u_clip (
    .x     (x_cur),
    .drive (fr_drive),
    .mode  (fr_mode),
    .w     (w_cu)
  );

  // TONE and MIX never overlap, so one multiplier serves both stages.
  always_comb begin
    if (state == ST_TONE) begin
      mul_a = (DATA_W+1)'(w_r) - (DATA_W+1)'(s_cur);
      mul_b = $signed({2'b00, fr_tone}) + (PARAM_W+2)'(1);
    end else begin
      mul_a = (DATA_W+1)'(y_r) - (DATA_W+1)'(x_cur);
      mul_b = $signed({2'b00, fr_mix});
    end
    prod  = M_W'(mul_a) * M_W'(mul_b);
    acc   = prod >>> PARAM_W;
    // Both results are convex blends, so wrapping DATA_W adds land in range.
    y_nxt = s_cur + DATA_W'(acc);
    o_nxt = (fr_mix == '1) ? y_r : x_cur + DATA_W'(acc);
    out_nxt     = out_buf;
    out_nxt[ch] = o_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      ch            <= '0;
      fr_x          <= '0;
      fr_drive      <= '0;
      fr_tone       <= '0;
      fr_mix        <= '0;
      fr_mode       <= FX_BYPASS;
      lpf           <= '0;
      out_buf       <= '0;
      w_r           <= '0;
      y_r           <= '0;
      bus.audio_out <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.sample_en && state != ST_IDLE) bus.overrun <= 1'b1;
      case (state)
        ST_IDLE: if (bus.sample_en) begin
          fr_x     <= bus.audio_in;
          fr_drive <= bus.fx_drive;
          fr_tone  <= bus.fx_tone;
          fr_mix   <= bus.fx_mix;
          fr_mode  <= fx_mode_e'(bus.fx_mode);
          ch       <= '0;
          bus.busy <= 1'b1;
          state    <= ST_GAIN;
        end
        ST_GAIN: state <= ST_CLIP;
        ST_CLIP: begin
          w_r   <= w_cu;
          state <= ST_TONE;
        end
        ST_TONE: begin
          y_r     <= y_nxt;
          lpf[ch] <= y_nxt;
          state   <= ST_MIX;
        end
        ST_MIX: begin
          out_buf[ch] <= o_nxt;
          if (ch == CH_W'(N_CH - 1)) begin
            bus.audio_out <= out_nxt;
            bus.out_valid <= 1'b1;
            state         <= ST_DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= ST_GAIN;
          end
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_overdrive.sv
// Directed bench for fx_overdrive: frames queue their expected output when
// driven, and each out_valid pops and checks one entry.
module tb_fx_overdrive;
  localparam int DATA_W  = 16;
  localparam int PARAM_W = 8;
  localparam int N_CH    = 2;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fx_overdrive_if #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .N_CH(N_CH)) bus ();

  fx_overdrive #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .N_CH(N_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   lpf_m[2];
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference per-channel computation in plain integer arithmetic.
  function automatic int model_ch(int x, int drive, int tone, int mix, int mode, int ci);
    longint p, m, w, y, o;
    p = (longint'(x) * (16 + drive)) >>> 4;
    if (mode == 2) begin
      m = (p < 0) ? -p : p;
      if (m > 16384) begin
        m = 16384 + ((m - 16384) >>> 2);
        p = (p < 0) ? -m : m;
      end
    end
    w = (p > 32767) ? 32767 : (p < -32768) ? -32768 : p;
    y = lpf_m[ci] + (((w - lpf_m[ci]) * (tone + 1)) >>> 8);
    lpf_m[ci] = int'(y);
    o = (mix == 255) ? y : x + (((y - x) * mix) >>> 8);
    return int'(o);
  endfunction

  task automatic send(input logic [15:0] x0, input logic [15:0] x1, input int drv,
                      input int tn, input int mx, input int md, input bit push,
                      input bit use_const, input logic [15:0] c0, input logic [15:0] c1,
                      input string tag);
    exp_t e;
    int   m0, m1;
    m0 = model_ch(int'($signed(x0)), drv, tn, mx, md, 0);
    m1 = model_ch(int'($signed(x1)), drv, tn, mx, md, 1);
    e.e0  = use_const ? c0 : 16'(m0);
    e.e1  = use_const ? c1 : 16'(m1);
    e.tag = tag;
    if (push) sb.push_back(e);
    bus.sample_en = 1'b1;
    bus.audio_in  = {x1, x0};
    bus.fx_drive  = 8'(drv);
    bus.fx_tone   = 8'(tn);
    bus.fx_mix    = 8'(mx);
    bus.fx_mode   = 2'(md);
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    // Scramble the ports: the latched frame must be what gets processed.
    bus.audio_in  = $urandom;
    bus.fx_drive  = 8'($urandom);
    bus.fx_tone   = 8'($urandom);
    bus.fx_mix    = 8'($urandom);
    bus.fx_mode   = 2'($urandom);
  endtask

  task automatic wait_out(input int pulse_at);
    exp_t e;
    int   k;
    bit   seen;
    k    = 0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      k++;
      @(posedge clk); #1;
      bus.sample_en = (k == pulse_at);
      if (k == pulse_at) bus.audio_in = 32'h5555AAAA;
      if (bus.out_valid) seen = 1'b1;
    end
    bus.sample_en = 1'b0;
    if (seen) begin
      e = sb.pop_front();
      chk({e.tag, "_latency"}, k + 1, 9);
      chk({e.tag, "_ch0"}, bus.audio_out[0], e.e0);
      chk({e.tag, "_ch1"}, bus.audio_out[1], e.e1);
      @(posedge clk); #1;
      chk({e.tag, "_valid_pulse"}, bus.out_valid, 0);
      chk({e.tag, "_busy_clr"}, bus.busy, 0);
    end else begin
      chk("out_valid_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    lpf_m[0] = 0;
    lpf_m[1] = 0;
    bus.sample_en = 1'b0;
    bus.audio_in  = '0;
    bus.fx_drive  = '0;
    bus.fx_tone   = '0;
    bus.fx_mix    = '0;
    bus.fx_mode   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_audio_out", bus.audio_out, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send(16'h1234, 16'hEDCC, 0, 255, 255, 0, 1, 1, 16'h1234, 16'hEDCC, "unity");
    wait_out(0);
    send(16'h1000, 16'hF000, 255, 255, 255, 1, 1, 1, 16'h7FFF, 16'h8000, "hard");
    wait_out(0);
    send(16'h3000, 16'hD000, 16, 255, 255, 2, 1, 1, 16'h4800, 16'hB800, "soft");
    wait_out(0);

    // Reset during cycle 3 of a frame: abort it and clear everything.
    send(16'h2000, 16'h1111, 10, 100, 200, 1, 0, 0, 16'h0, 16'h0, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_audio_out", bus.audio_out, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_overrun", bus.overrun, 0);
    lpf_m[0] = 0;
    lpf_m[1] = 0;
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);

    send(16'h4000, 16'h0000, 0, 127, 255, 0, 1, 1, 16'h2000, 16'h0000, "tone1");
    wait_out(0);
    send(16'h4000, 16'h0000, 0, 127, 255, 0, 1, 1, 16'h3000, 16'h0000, "tone2");
    wait_out(0);
    send(16'h4000, 16'h0000, 0, 127, 255, 0, 1, 1, 16'h3800, 16'h0000, "tone3");
    wait_out(0);

    chk("overrun_pre", bus.overrun, 0);
    send(16'h0123, 16'hFEDC, 255, 255, 0, 1, 1, 1, 16'h0123, 16'hFEDC, "dry_overrun");
    wait_out(3);
    chk("overrun_set", bus.overrun, 1);

    send(16'hC000, 16'h2222, 200, 60, 180, 2, 1, 0, 16'h0, 16'h0, "mix_soft");
    wait_out(0);
    send(16'h7FFF, 16'h8000, 40, 200, 100, 3, 1, 0, 16'h0, 16'h0, "mix_rsvd");
    wait_out(0);
    send(16'h0555, 16'hF9AB, 5, 0, 254, 0, 1, 0, 16'h0, 16'h0, "mix_gain");
    wait_out(0);
    chk("overrun_sticky", bus.overrun, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
